debug_cmd_bridge: RTL

DEBUG_CMD_BRIDGE -- requirements
Module: debug_cmd_bridge

---
 rtl/debug_cmd_bridge_pkg.sv | 19 +
 rtl/debug_sync_bit.sv | 23 ++
 rtl/debug_cmd_bridge.sv | 129 ++++++++++++
 3 files changed

// File: rtl/debug_cmd_bridge_pkg.sv
// Shared constants and helpers for the debug command bridge: default widths,
// channel-count function and the position of the action bit in a command.
package debug_cmd_bridge_pkg;

    localparam int DEF_DR_WIDTH    = 38;
    localparam int DEF_IR_WIDTH    = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FIFO_DEPTH  = 4;

    function automatic int num_channels(input int ir_width);
        return 1 << ir_width;
    endfunction

    // The action flag is the most significant bit of the shifted data register.
    function automatic int action_bit(input int dr_width);
        return dr_width - 1;
    endfunction

endpackage

// File: rtl/debug_sync_bit.sv
// Single-bit multi-flop synchronizer for JTAG-domain levels entering the clk domain.
module debug_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_p <= '0;
        end else begin
            chain_p <= {chain_p[STAGES-2:0], d};
        end
    end

    assign q = chain_p[STAGES-1];

endmodule

// File: rtl/debug_cmd_bridge.sv
// Moves JTAG update-DR commands into the clk domain, queues them, and emits a
// per-channel action / no-action strobe one cycle after each command is consumed.
module debug_cmd_bridge
    import debug_cmd_bridge_pkg::*;
#(
    parameter int  DR_WIDTH    = DEF_DR_WIDTH,
    parameter int  IR_WIDTH    = DEF_IR_WIDTH,
    parameter int  SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int  FIFO_DEPTH  = DEF_FIFO_DEPTH,
    localparam int NCH         = num_channels(IR_WIDTH),
    localparam int AW          = $clog2(FIFO_DEPTH),
    localparam int LW          = AW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vs_udr,
    input  logic                vs_uir,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic [DR_WIDTH-1:0] sr,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [IR_WIDTH-1:0] cmd_ir,
    output logic [DR_WIDTH-1:0] cmd_data,
    output logic [NCH-1:0]      take_action,
    output logic [NCH-1:0]      take_no_action,
    output logic [LW-1:0]       level,
    output logic                overflow
);

    localparam int ACT_BIT = action_bit(DR_WIDTH);
    localparam int ARM_W   = $clog2(SYNC_STAGES + 2);

    logic             udr_s, uir_s, udr_d, uir_d;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed, udr_evt, uir_evt;

    debug_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_udr (
        .clk(clk), .reset(reset), .d(vs_udr), .q(udr_s)
    );
    debug_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_uir (
        .clk(clk), .reset(reset), .d(vs_uir), .q(uir_s)
    );

    // Edges are ignored until the chains have flushed their reset zeros, so a
    // level already high at reset release is not mistaken for a new event.
    assign armed = (arm_cnt == ARM_W'(SYNC_STAGES + 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_d   <= 1'b0;
            uir_d   <= 1'b0;
            arm_cnt <= '0;
        end else begin
            udr_d <= udr_s;
            uir_d <= uir_s;
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

    assign udr_evt = armed & udr_s & ~udr_d;
    assign uir_evt = armed & uir_s & ~uir_d;

    // ---- command queue ----
    logic [IR_WIDTH-1:0] mem_ir   [FIFO_DEPTH];
    logic [DR_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                full, pop, push, drop;

    assign full      = (level == LW'(FIFO_DEPTH));
    assign cmd_valid = (level != '0);
    assign cmd_ir    = mem_ir[rd_ptr];
    assign cmd_data  = mem_data[rd_ptr];
    assign pop       = cmd_valid & cmd_ready;
    assign push      = udr_evt & (~full | pop);
    assign drop      = udr_evt & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ir[wr_ptr]   <= ir_in;
            mem_data[wr_ptr] <= sr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (uir_evt) begin
                overflow <= 1'b0;
            end
        end
    end

    // ---- strobe stage: one cycle after the pop ----
    logic [NCH-1:0] head_onehot;
    logic           head_act;

    assign head_onehot = NCH'(1) << cmd_ir;
    assign head_act    = cmd_data[ACT_BIT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= (pop && head_act)  ? head_onehot : '0;
            take_no_action <= (pop && !head_act) ? head_onehot : '0;
        end
    end

endmodule
